// File: rtl/vco_adc_sequencer.sv
// Purpose: VCO ADC conversion sequencer. Counts synchronized phase transitions over a window and queues samples.
// Latency: phase change reaches inc after 3 cycles; a pushed sample is visible on rd_data one cycle after its push.
// Backpressure: none upstream; a push into a full FIFO with no coincident pop is dropped and sets sticky overflow.

module vco_adc_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 4,
  parameter int LVL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [W-1:0]     i_push_dat,
  input  logic             i_pop,
  output logic [W-1:0]     o_dat,
  output logic [LVL_W-1:0] o_level,
  output logic             o_drop
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LVL_W-1:0] r_level;

  logic w_empty;
  logic w_full;
  logic w_pop_ok;
  logic w_push_ok;

  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == LVL_W'(DEPTH));
  // A pop on empty is ignored; a push on full only lands if a pop frees the head slot.
  assign w_pop_ok  = i_pop && !w_empty;
  assign w_push_ok = i_push && (!w_full || w_pop_ok);
  assign o_drop    = i_push && !w_push_ok;
  assign o_dat     = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_level   = r_level;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_push_dat;
  end
endmodule

module vco_adc_sequencer #(
  parameter int PHASES = 11,
  parameter int WIN_W  = 16,
  parameter int ACC_W  = 24,
  parameter int DEPTH  = 4
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [PHASES-1:0] phase_in,
  input  logic [WIN_W-1:0]  cfg_window,
  input  logic [7:0]        cfg_settle,
  input  logic [7:0]        cfg_count,
  input  logic [2:0]        cfg_irq_level,
  input  logic              start,
  input  logic              stop,
  input  logic              rd_en,
  input  logic              clr_ovf,
  output logic [ACC_W-1:0]  rd_data,
  output logic [2:0]        fifo_level,
  output logic              busy,
  output logic              overflow,
  output logic              irq
);
  localparam int INC_W = $clog2(PHASES + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_ACCUM  = 2'd2;

  logic [PHASES-1:0] r_s1;
  logic [PHASES-1:0] r_s2;
  logic [PHASES-1:0] r_prev;
  logic [INC_W-1:0]  r_inc;

  logic [1:0]        r_state;
  logic [ACC_W-1:0]  r_acc;
  logic [WIN_W-1:0]  r_win_cnt;
  logic [WIN_W-1:0]  r_win_m1;
  logic [7:0]        r_settle_cnt;
  logic [7:0]        r_smp_cnt;
  logic [7:0]        r_cfg_settle;
  logic [7:0]        r_cfg_count;
  logic [2:0]        r_cfg_irq;
  logic              r_overflow;

  logic [PHASES-1:0] w_diff;
  logic [INC_W-1:0]  w_pop;
  logic [ACC_W:0]    w_sum;
  logic [ACC_W-1:0]  w_acc_sat;
  logic              w_win_last;
  logic              w_push;
  logic [7:0]        w_smp_next;
  logic              w_run_done;
  logic              w_drop;

  assign w_diff = r_s2 ^ r_prev;

  // Transition count between consecutive synchronized phase snapshots.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < PHASES; i++) begin
      w_pop = w_pop + {{(INC_W-1){1'b0}}, w_diff[i]};
    end
  end

  // Two-flop synchronizer, previous-snapshot register and registered increment.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_prev <= '0;
      r_inc  <= '0;
    end else begin
      r_s1   <= phase_in;
      r_s2   <= r_s1;
      r_prev <= r_s2;
      r_inc  <= w_pop;
    end
  end

  assign w_sum      = {1'b0, r_acc} + {{(ACC_W+1-INC_W){1'b0}}, r_inc};
  assign w_acc_sat  = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
  assign w_win_last = (r_win_cnt == r_win_m1);
  // stop takes priority, so a window that would close in the stop cycle is discarded too.
  assign w_push     = (r_state == S_ACCUM) && !stop && w_win_last;
  assign w_smp_next = r_smp_cnt + 8'd1;
  assign w_run_done = (r_cfg_count != 8'd0) && (w_smp_next == r_cfg_count);

  // Run control: configuration latch, settle countdown and windowed accumulation.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state      <= S_IDLE;
      r_acc        <= '0;
      r_win_cnt    <= '0;
      r_win_m1     <= '0;
      r_settle_cnt <= '0;
      r_smp_cnt    <= '0;
      r_cfg_settle <= '0;
      r_cfg_count  <= '0;
      r_cfg_irq    <= '0;
    end else if (stop) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_win_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cfg_settle <= cfg_settle;
            r_cfg_count  <= cfg_count;
            r_cfg_irq    <= cfg_irq_level;
            // A zero window behaves as a one-cycle window.
            r_win_m1     <= (cfg_window == '0) ? '0 : cfg_window - WIN_W'(1);
            r_acc        <= '0;
            r_win_cnt    <= '0;
            r_smp_cnt    <= '0;
            r_settle_cnt <= '0;
            r_state      <= (cfg_settle == 8'd0) ? S_ACCUM : S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_settle_cnt == r_cfg_settle - 8'd1) begin
            r_state <= S_ACCUM;
          end else begin
            r_settle_cnt <= r_settle_cnt + 8'd1;
          end
        end
        S_ACCUM: begin
          if (w_win_last) begin
            r_acc     <= '0;
            r_win_cnt <= '0;
            r_smp_cnt <= w_smp_next;
            if (w_run_done) r_state <= S_IDLE;
          end else begin
            r_acc     <= w_acc_sat;
            r_win_cnt <= r_win_cnt + WIN_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  vco_adc_fifo #(
    .W     (ACC_W),
    .DEPTH (DEPTH),
    .LVL_W (3)
  ) u_fifo (
    .clk        (wb_clk_i),
    .rst        (wb_rst_i),
    .i_push     (w_push),
    .i_push_dat (w_acc_sat),
    .i_pop      (rd_en),
    .o_dat      (rd_data),
    .o_level    (fifo_level),
    .o_drop     (w_drop)
  );

  // Sticky drop flag; a new drop beats a coincident clear.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clr_ovf) begin
      r_overflow <= 1'b0;
    end
  end

  assign overflow = r_overflow;
  assign busy     = (r_state != S_IDLE);
  assign irq      = (r_cfg_irq != 3'd0) && (fifo_level >= r_cfg_irq);
endmodule

// File: doc/vco_adc_sequencer.md
# vco_adc_sequencer

Conversion sequencer for the ring-oscillator VCO ADC. It samples the free-running 11-phase VCO output and counts phase transitions over a programmable window of clock cycles. Each completed window is pushed as one sample into a small first-word-fall-through (FWFT) FIFO, and an interrupt is raised on a fill threshold. It sits between the `vco` phase outputs and the wishbone register file in `vco_adc_wrapper`, which drives its configuration and start/stop pulses and pops samples.

## Interface

**Parameters**
- `PHASES`, 11: number of VCO phase taps.
- `WIN_W`, 16: width of the window-length field.
- `ACC_W`, 24: sample and accumulator width.
- `DEPTH`, 4: number of FIFO entries. Must be a power of 2.

**Ports**
- `wb_clk_i` in, 1: the single clock.
- `wb_rst_i` in, 1: asynchronous, active-high reset.
- `phase_in` in, PHASES: VCO phases, asynchronous to `wb_clk_i`.
- `cfg_window` in, WIN_W: window length in cycles. 0 is treated as 1.
- `cfg_settle` in, 8: cycles discarded after start.
- `cfg_count` in, 8: samples per run. 0 means continuous.
- `cfg_irq_level` in, 3: FIFO level that raises `irq`. 0 disables `irq`.
- `start` in, 1: single-cycle pulse that begins a run.
- `stop` in, 1: single-cycle pulse that aborts a run.
- `rd_en` in, 1: pop the FIFO head.
- `clr_ovf` in, 1: clears `overflow`.
- `rd_data` out, ACC_W: FIFO head (FWFT). Reads 0 when the FIFO is empty.
- `fifo_level` out, 3: number of entries, 0 to DEPTH.
- `busy` out, 1: high in SETTLE and ACCUM.
- `overflow` out, 1: sticky flag for a dropped sample.
- `irq` out, 1: level-sensitive interrupt.

## Operation

**Phase front end**
- `phase_in` passes through a 2-flop synchronizer, giving `s2`.
- `prev` <= `s2` every cycle.
- `inc` <= popcount(`s2` ^ `prev`), registered. `inc` ranges 0 to 11 and is computed in every state.

**State machine: IDLE, SETTLE, ACCUM**
- IDLE, on `start`:
  - Latch all `cfg_*` inputs. Later changes to `cfg_*` have no effect until the next start.
  - Clear the accumulator, window counter and sample counter.
  - Go to SETTLE, or go directly to ACCUM if `cfg_settle`=0.
- SETTLE: count `cfg_settle` cycles with `inc` ignored, then go to ACCUM.
- ACCUM: `acc` <= `acc` + `inc` each cycle.
  - `acc` saturates at 2^ACC_W-1.
  - On the W-th cycle, where W = max(`cfg_window`,1), push sat(`acc`+`inc`) to the FIFO and set `acc` <= 0.
  - Windows run back-to-back with no gap cycle.
  - After a push, the sample counter increments. When it equals `cfg_count` (nonzero), go to IDLE. Otherwise stay in ACCUM.
- `stop` in any state: go to IDLE on the next cycle and discard the partial window. FIFO contents are retained.
- `stop` and `start` in the same cycle: `stop` wins, and the block ends in IDLE.
- `start` while `busy` is high is ignored.

**FIFO**
- Push when full: the sample is dropped and `overflow` is set.
- Pop (`rd_en`) when empty: ignored, no state change.
- Push and pop in the same cycle when full: both succeed and the level is unchanged.
- Push and pop in the same cycle when empty: the pop is ignored and the level becomes 1.
- `clr_ovf` coincident with a new overflow: `overflow` stays 1.

**Interrupt**
- `irq` = (`cfg_irq_level` != 0) && (`fifo_level` >= `cfg_irq_level`).
- `irq` is driven from the registered `fifo_level` and the latched `cfg_irq_level`.

## Timing

- **Reset values:**
  - State is IDLE.
  - All counters and `acc` are 0.
  - `s1`, `s2`, `prev` and `inc` are 0.
  - FIFO is empty; `rd_data`=0, `fifo_level`=0.
  - `busy`=0, `overflow`=0, `irq`=0.
- **Reset mid-run:** all of the above apply immediately, because reset is asynchronous. FIFO contents are lost.
- **Input latency:** a `phase_in` change reaches `inc` 3 cycles later (2 synchronizer flops plus the `inc` register). `acc` includes it on the 4th cycle.
- **`busy`:** rises the cycle after `start`. It falls the cycle after the final push or after `stop`.
- **Push visibility:** a pushed sample appears on `rd_data` and in `fifo_level` the cycle after the push cycle. `irq` updates in that same cycle.
- **Pop:** `rd_en` at edge N shows the next entry on `rd_data` after edge N.
- **Throughput:** one sample every W cycles.

## Test plan

1. **Nominal run.**
   - Stimulus: one phase bit toggles every cycle (`inc`=1); `cfg_settle`=4, `cfg_window`=10, `cfg_count`=3.
   - Required: three samples of 10 at cycles 14, 24 and 34 after `start`; `fifo_level`=3; `busy` falls after the third push; `irq` set with level 2.
2. **Continuous run with overflow.**
   - Stimulus: `cfg_count`=0, `cfg_window`=1, 3 bits toggling per cycle; no pops.
   - Required: FIFO fills to 4 entries of 3; the 5th push sets `overflow`; `clr_ovf` clears it only if no further drop occurs in that cycle.
3. **Simultaneous push and pop at full.**
   - Stimulus: full FIFO; `rd_en` held high during continuous pushes.
   - Required: `fifo_level` stays 4, `overflow` stays 0, and `rd_data` advances in FIFO order.
4. **Stop mid-window.**
   - Stimulus: `stop` 5 cycles into a 10-cycle window; `start` and `stop` pulsed together afterwards.
   - Required: no partial sample is pushed; IDLE next cycle; the coincident pulse leaves the block in IDLE.
5. **Edge configurations.**
   - Stimulus: `cfg_window`=0 with `inc`=11; `phase_in` static; `cfg_irq_level`=0.
   - Required: `cfg_window`=0 gives one sample of 11 per cycle; static `phase_in` gives samples of 0; `irq` never asserts with `cfg_irq_level`=0.
6. **Async reset mid-run.**
   - Stimulus: assert `wb_rst_i` off-edge with `fifo_level`=2, mid-ACCUM.
   - Required: all outputs reset without waiting for a clock edge; after release, `start` behaves as in scenario 1.
